bv_stage_sequencer: RTL and testbench

Issues lookup requests into the bit-vector stage-enable chain and receives them back at the far end. Accepts a key over a valid/ready handshake and launches a one-cycle stage enable with a registered key into stage 0. It then takes the enable returned by the last stage and reports completion with measured pipeline latency. Tracks outstanding requests, flags timeouts and spurious returns; sits between the OpenFlow parser output and the bv-288 lookup pipeline.

---
 rtl/bv_stage_sequencer.sv | 113 +++++++++++
 tb/tb_bv_stage_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bv_stage_sequencer.sv
// Launch/return sequencer for the bit-vector stage-enable chain: issues keys into
// stage 0, timestamps each launch and reports latency when the enable comes back.
module bv_stage_sequencer #(
  parameter int KEY_WIDTH       = 288,
  parameter int NUM_STAGES      = 9,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key_valid,
  input  logic [KEY_WIDTH-1:0]               key_in,
  output logic                               key_ready,
  output logic                               stage_enable_out,
  output logic [KEY_WIDTH-1:0]               stage_key_out,
  input  logic                               stage_enable_in,
  output logic                               result_valid,
  output logic [7:0]                         result_latency,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [1:0]                         err_status,
  input  logic                               err_clear
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  if ((MAX_OUTSTANDING < 2) || (MAX_OUTSTANDING > 8) ||
      ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_max_outstanding
    $error("MAX_OUTSTANDING must be a power of 2 in 2..8");
  end

  if ((TIMEOUT < 2) || (TIMEOUT > 255) || (NUM_STAGES >= TIMEOUT)) begin : g_bad_timeout
    $error("TIMEOUT must be in 2..255 and exceed NUM_STAGES");
  end

  logic [7:0]       cycle_cnt_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] occ_r;
  logic [CNT_W-1:0] occ_s;
  logic [7:0]       ts_mem_r [MAX_OUTSTANDING];
  logic [1:0]       err_r;
  logic [1:0]       err_s;
  logic [7:0]       head_age_s;
  logic             issue_s;
  logic             ret_s;
  logic             spurious_s;
  logic             timeout_s;

  // A timing-out cycle also closes the handshake so an accepted key is never flushed.
  assign key_ready   = (occ_r < CNT_W'(MAX_OUTSTANDING)) && !err_r[0] && !timeout_s;
  assign outstanding = occ_r;
  assign err_status  = err_r;

  // Issue/return/error decode and next in-flight count
  always_comb begin
    issue_s    = key_valid && key_ready;
    head_age_s = cycle_cnt_r - ts_mem_r[rd_ptr_r];
    timeout_s  = (occ_r != {CNT_W{1'b0}}) && (head_age_s >= 8'(TIMEOUT));
    ret_s      = stage_enable_in && !err_r[0] && !timeout_s && (occ_r != {CNT_W{1'b0}});
    spurious_s = stage_enable_in && !err_r[0] && (occ_r == {CNT_W{1'b0}});
    err_s[0]   = timeout_s  | (err_r[0] & ~err_clear);
    err_s[1]   = spurious_s | (err_r[1] & ~err_clear);
    if (timeout_s) begin
      occ_s = {CNT_W{1'b0}};
    end else begin
      case ({issue_s, ret_s})
        2'b10:   occ_s = occ_r + CNT_W'(1);
        2'b01:   occ_s = occ_r - CNT_W'(1);
        default: occ_s = occ_r;
      endcase
    end
  end

  // Launch, timestamp FIFO, completion reporting and sticky error state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r      <= 8'd0;
      wr_ptr_r         <= {PTR_W{1'b0}};
      rd_ptr_r         <= {PTR_W{1'b0}};
      occ_r            <= {CNT_W{1'b0}};
      err_r            <= 2'b00;
      stage_enable_out <= 1'b0;
      stage_key_out    <= {KEY_WIDTH{1'b0}};
      result_valid     <= 1'b0;
      result_latency   <= 8'd0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        ts_mem_r[i] <= 8'd0;
      end
    end else begin
      cycle_cnt_r      <= cycle_cnt_r + 8'd1;
      stage_enable_out <= issue_s;
      result_valid     <= ret_s;
      occ_r            <= occ_s;
      err_r            <= err_s;
      // Timestamp is the counter value during the launch cycle itself.
      if (issue_s) begin
        stage_key_out      <= key_in;
        ts_mem_r[wr_ptr_r] <= cycle_cnt_r + 8'd1;
        wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
      end
      if (timeout_s) begin
        rd_ptr_r <= wr_ptr_r;
      end else if (ret_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (ret_s) begin
        result_latency <= head_age_s;
      end
    end
  end

endmodule

// File: tb/tb_bv_stage_sequencer.sv
// Directed bench for bv_stage_sequencer: stage chain modelled as a programmable
// delay line from stage_enable_out back to stage_enable_in.
module tb_bv_stage_sequencer;

  localparam int KW = 288;

  logic          clk;
  logic          reset;
  logic          key_valid;
  logic [KW-1:0] key_in;
  logic          key_ready;
  logic          stage_enable_out;
  logic [KW-1:0] stage_key_out;
  logic          stage_enable_in;
  logic          result_valid;
  logic [7:0]    result_latency;
  logic [2:0]    outstanding;
  logic [1:0]    err_status;
  logic          err_clear;

  logic          manual_ret;
  logic          loop_en;
  logic [3:0]    loop_delay;
  logic [15:0]   dly_q;
  logic [7:0]    ref_cnt;

  int n_checks;
  int n_fail;

  bv_stage_sequencer #(
    .KEY_WIDTH(KW), .NUM_STAGES(9), .MAX_OUTSTANDING(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .stage_enable_out(stage_enable_out),
    .stage_key_out(stage_key_out), .stage_enable_in(stage_enable_in),
    .result_valid(result_valid), .result_latency(result_latency),
    .outstanding(outstanding), .err_status(err_status), .err_clear(err_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) dly_q <= {dly_q[14:0], stage_enable_out};

  always @(posedge clk or negedge reset) begin
    if (!reset) ref_cnt <= 8'd0;
    else        ref_cnt <= ref_cnt + 8'd1;
  end

  always_comb begin
    stage_enable_in = manual_ret |
      (loop_en & ((loop_delay == 4'd0) ? stage_enable_out : dly_q[loop_delay - 4'd1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    dly_q      = 16'd0;
    reset      = 1'b0;
    key_valid  = 1'b0;
    key_in     = '0;
    err_clear  = 1'b0;
    manual_ret = 1'b0;
    loop_en    = 1'b0;
    loop_delay = 4'd9;

    // Reset state
    repeat (3) tick();
    check("rst_en_out", stage_enable_out, 0);
    check("rst_key_out", stage_key_out, 0);
    check("rst_rv", result_valid, 0);
    check("rst_lat", result_latency, 0);
    check("rst_occ", outstanding, 0);
    check("rst_err", err_status, 0);
    check("rst_ready", key_ready, 1);
    reset = 1'b1;
    tick();
    tick();

    // Single key, 9-cycle loopback
    loop_en   = 1'b1;
    loop_delay = 4'd9;
    key_in    = 288'h1234;
    key_valid = 1'b1;
    check("s1_ready", key_ready, 1);
    tick();
    key_valid = 1'b0;
    check("s1_launch", stage_enable_out, 1);
    check("s1_key", stage_key_out, 288'h1234);
    check("s1_occ1", outstanding, 1);
    tick();
    check("s1_launch_once", stage_enable_out, 0);
    repeat (8) tick();
    check("s1_rv_early", result_valid, 0);
    check("s1_occ_wait", outstanding, 1);
    tick();
    check("s1_rv", result_valid, 1);
    check("s1_lat", result_latency, 9);
    check("s1_occ0", outstanding, 0);
    tick();
    check("s1_rv_pulse", result_valid, 0);
    check("s1_lat_hold", result_latency, 9);

    // Back-to-back issue up to MAX_OUTSTANDING
    key_valid = 1'b1;
    key_in    = 288'hA1;
    check("s2_ready0", key_ready, 1);
    tick(); key_in = 288'hA2;
    check("s2_occ1", outstanding, 1);
    check("s2_launch", stage_enable_out, 1);
    tick(); key_in = 288'hA3;
    check("s2_occ2", outstanding, 2);
    tick(); key_in = 288'hA4;
    check("s2_occ3", outstanding, 3);
    tick(); key_in = 288'hA5;
    check("s2_occ4", outstanding, 4);
    check("s2_full", key_ready, 0);
    check("s2_key4", stage_key_out, 288'hA4);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s2_occ_full", outstanding, 4);
      check("s2_ready_full", key_ready, 0);
      check("s2_rv_wait", result_valid, 0);
    end
    tick();
    check("s2_rv1", result_valid, 1);
    check("s2_lat1", result_latency, 9);
    check("s2_occ_after_ret", outstanding, 3);
    check("s2_ready_again", key_ready, 1);
    tick();
    key_in = 288'hA6;
    check("s2_occ_swap1", outstanding, 3);
    check("s2_rv2", result_valid, 1);
    check("s2_relaunch", stage_enable_out, 1);
    check("s2_key5", stage_key_out, 288'hA5);
    tick();
    key_valid = 1'b0;
    check("s2_occ_swap2", outstanding, 3);
    check("s2_key6", stage_key_out, 288'hA6);
    tick();
    check("s2_occ_drain", outstanding, 2);
    check("s2_lat4", result_latency, 9);
    repeat (8) tick();
    check("s2_occ_late1", outstanding, 1);
    check("s2_rv5", result_valid, 1);
    tick();
    check("s2_occ_late0", outstanding, 0);
    check("s2_lat6", result_latency, 9);
    check("s2_err", err_status, 0);

    // Zero-delay loopback with continuous issue
    loop_delay = 4'd0;
    key_in     = 288'hC0;
    key_valid  = 1'b1;
    tick();
    check("s3_occ_first", outstanding, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s3_occ_steady", outstanding, 1);
      check("s3_rv", result_valid, 1);
      check("s3_lat0", result_latency, 0);
      check("s3_err", err_status, 0);
    end
    key_valid = 1'b0;
    tick();
    check("s3_occ_end", outstanding, 0);
    check("s3_rv_last", result_valid, 1);
    tick();
    check("s3_rv_idle", result_valid, 0);
    check("s3_err_end", err_status, 0);

    // Timeout with no return
    loop_en   = 1'b0;
    key_in    = 288'hD0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("s4_occ1", outstanding, 1);
    repeat (64) tick();
    check("s4_err_pre", err_status, 0);
    check("s4_occ_pre", outstanding, 1);
    tick();
    check("s4_err_to", err_status, 2'b01);
    check("s4_occ_flush", outstanding, 0);
    check("s4_ready_blk", key_ready, 0);
    manual_ret = 1'b1;
    tick();
    manual_ret = 1'b0;
    check("s4_ret_ignored", err_status, 2'b01);
    check("s4_rv_ignored", result_valid, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("s4_err_clr", err_status, 0);
    check("s4_ready_back", key_ready, 1);

    // Spurious returns and clear/set collision
    manual_ret = 1'b1;
    tick();
    manual_ret = 1'b0;
    check("s5_spur", err_status, 2'b10);
    check("s5_rv", result_valid, 0);
    check("s5_ready", key_ready, 1);
    manual_ret = 1'b1;
    err_clear  = 1'b1;
    tick();
    manual_ret = 1'b0;
    err_clear  = 1'b0;
    check("s5_set_wins", err_status, 2'b10);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("s5_clr", err_status, 0);

    // Latency across cycle counter wrap: launch at count 250
    loop_en    = 1'b1;
    loop_delay = 4'd9;
    for (int i = 0; i < 300 && ref_cnt != 8'd249; i++) tick();
    key_in    = 288'hE0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("s6_launch", stage_enable_out, 1);
    repeat (9) tick();
    check("s6_rv_early", result_valid, 0);
    tick();
    check("s6_rv", result_valid, 1);
    check("s6_lat_wrap", result_latency, 9);

    // Reset with three requests in flight, late returns become spurious
    key_valid = 1'b1;
    key_in    = 288'hF1;
    tick(); key_in = 288'hF2;
    tick(); key_in = 288'hF3;
    tick();
    key_valid = 1'b0;
    check("s7_occ3", outstanding, 3);
    #2;
    reset = 1'b0;
    #1;
    check("s7_rst_en", stage_enable_out, 0);
    check("s7_rst_key", stage_key_out, 0);
    check("s7_rst_rv", result_valid, 0);
    check("s7_rst_lat", result_latency, 0);
    check("s7_rst_occ", outstanding, 0);
    check("s7_rst_err", err_status, 0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    check("s7_err_pre", err_status, 0);
    tick();
    check("s7_late_spur", err_status, 2'b10);
    check("s7_late_rv", result_valid, 0);
    check("s7_late_occ", outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
